// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad emulator.
package keypad_pkg;

  localparam int KEY_W = 4;

  // Row and column lines are active-low; all ones means no contact / no strobe.
  localparam logic [3:0] ROW_IDLE = 4'b1111;
  localparam logic [3:0] COL_IDLE = 4'b1111;

  // key_code layout: [3:2] row index, [1:0] column index.
  localparam int ROW_IDX_MSB = 3;
  localparam int ROW_IDX_LSB = 2;
  localparam int COL_IDX_MSB = 1;
  localparam int COL_IDX_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [1:0] row_idx(input logic [KEY_W-1:0] key);
    return key[ROW_IDX_MSB:ROW_IDX_LSB];
  endfunction

  function automatic logic [1:0] col_idx(input logic [KEY_W-1:0] key);
    return key[COL_IDX_MSB:COL_IDX_LSB];
  endfunction

endpackage

// File: rtl/keypad_emu_fifo.sv
// Key-code queue between the host and the press sequencer.
// dout always shows the head entry; a push while full is dropped even if a
// pop happens on the same edge.
module keypad_emu_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [KEY_W-1:0] din,
  output logic [KEY_W-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [KEY_W-1:0] mem_q [DEPTH];
  logic [KEY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Next pointers, occupancy and storage; pointers wrap naturally at DEPTH.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Queue state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad emulator: presses queued keys one at a time and answers
// the scanner's active-low column strobes on the active-low row lines.
//
// state | meaning
// IDLE  | no key pressed; pops the next queued key when one is available
// PRESS | cur_key held down for HOLD_CYCLES cycles
// GAP   | key released for GAP_CYCLES cycles before the next one
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 1000,
  parameter int GAP_CYCLES  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  output logic             key_ready,
  input  logic [3:0]       col,
  output logic [3:0]       row,
  output logic             active,
  output logic             done,
  output logic             busy
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] cur_key_q, cur_key_d;
  logic             done_q, done_d;
  logic [3:0]       row_q, row_d;
  logic [3:0]       col_low;
  logic             fifo_pop;
  logic [KEY_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;

  keypad_emu_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (key_valid),
    .pop  (fifo_pop),
    .din  (key_code),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign key_ready = !fifo_full;
  assign active    = (state_q == PRESS);
  assign done      = done_q;
  assign row       = row_q;
  assign busy      = !fifo_empty || (state_q != IDLE);

  // Active-high view of the column strobes; X on col propagates unfiltered.
  assign col_low = col ^ COL_IDLE;

  // Press sequencer with down-counting hold/gap timer, plus the row response.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_key_d = cur_key_q;
    done_d    = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          cur_key_d = fifo_dout;
          cnt_d     = HOLD_LOAD;
          state_d   = PRESS;
        end
      end
      PRESS: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LOAD;
          done_d  = 1'b1;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The pressed key shorts its row to its column: the row goes low while
    // the scanner strobes that column, regardless of other strobed columns.
    row_d = ROW_IDLE;
    if ((state_q == PRESS) && col_low[col_idx(cur_key_q)]) begin
      row_d[row_idx(cur_key_q)] = 1'b0;
    end
  end

  // Sequencer and row register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_key_q <= '0;
      done_q    <= 1'b0;
      row_q     <= ROW_IDLE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_key_q <= cur_key_d;
      done_q    <= done_d;
      row_q     <= row_d;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator with HOLD_CYCLES=8, GAP_CYCLES=4, DEPTH=4.
module tb_keypad_emulator;
  import keypad_pkg::*;

  localparam int HOLD = 8;
  localparam int GAPC = 4;
  localparam int SPACING = HOLD + GAPC + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] col;
  logic [3:0] row;
  logic       active;
  logic       done;
  logic       busy;

  keypad_emulator #(
    .DEPTH      (4),
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAPC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .col      (col),
    .row      (row),
    .active   (active),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] col;
    logic [3:0] exp_row;
  } scan_vec_t;

  typedef struct {
    logic [3:0] code;
    logic       exp_ready;
  } push_vec_t;

  scan_vec_t scan_tbl[8];
  push_vec_t push_tbl[6];

  int pass_n = 0;
  int total_n = 0;

  // Activity recorder, updated on every tick while rec_en is set.
  bit         rec_en;
  int         cyc, act_n, done_n, row_n, first_act, first_row;
  int         done_t[$];
  logic [3:0] rows[$];
  logic [3:0] prev_row;
  logic [3:0] exp_rows[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_stats();
    cyc = 0; act_n = 0; done_n = 0; row_n = 0;
    first_act = -1; first_row = -1;
    done_t.delete(); rows.delete();
    prev_row = ROW_IDLE;
  endtask

  task automatic tick();
    @(negedge clk);
    if (rec_en) begin
      cyc++;
      if (active === 1'b1) begin
        act_n++;
        if (first_act < 0) first_act = cyc;
      end
      if (done === 1'b1) begin
        done_n++;
        done_t.push_back(cyc);
      end
      if (row !== ROW_IDLE) begin
        row_n++;
        if (first_row < 0) first_row = cyc;
        if (prev_row === ROW_IDLE) rows.push_back(row);
      end
      prev_row = row;
    end
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic check_spacing(input string name);
    for (int i = 1; i < done_t.size(); i++)
      check(name, 32'(done_t[i] - done_t[i-1]), 32'(SPACING));
  endtask

  task automatic check_rows(input string name);
    check({name, "_count"}, 32'(rows.size()), 32'(exp_rows.size()));
    for (int i = 0; i < exp_rows.size(); i++)
      check($sformatf("%s[%0d]", name, i),
            (i < rows.size()) ? 32'(rows[i]) : 32'hFFFF_FFFF, 32'(exp_rows[i]));
  endtask

  initial begin
    // Key 4'b1100 = row 3, column 0: row[3] drops iff col[0] is low.
    scan_tbl[0] = '{4'b1110, 4'b0111};
    scan_tbl[1] = '{4'b1101, 4'b1111};
    scan_tbl[2] = '{4'b1011, 4'b1111};
    scan_tbl[3] = '{4'b0111, 4'b1111};
    scan_tbl[4] = '{4'b1111, 4'b1111};
    scan_tbl[5] = '{4'b0000, 4'b0111};
    scan_tbl[6] = '{4'b1010, 4'b0111};
    scan_tbl[7] = '{4'b0101, 4'b1111};

    // Back-to-back pushes: the first key is popped one edge after it lands,
    // so five are taken and the sixth meets a full queue.
    push_tbl[0] = '{4'b0000, 1'b1};
    push_tbl[1] = '{4'b0101, 1'b1};
    push_tbl[2] = '{4'b1010, 1'b1};
    push_tbl[3] = '{4'b1111, 1'b1};
    push_tbl[4] = '{4'b0011, 1'b0};
    push_tbl[5] = '{4'b0100, 1'b0};

    rec_en = 1'b0;
    clear_stats();

    // Reset with key_valid held high.
    rst = 1'b1; key_valid = 1'b1; key_code = 4'b0101; col = 4'b0000;
    tick(); tick();
    check("rst_row",    32'(row),       32'hF);
    check("rst_ready",  32'(key_ready), 32'd1);
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_active", 32'(active),    32'd0);
    check("rst_done",   32'(done),      32'd0);
    rst = 1'b0; key_valid = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    tick(); tick();
    check("post_rst_active", 32'(active), 32'd0);

    // Single key: row 1, column 2, column 2 strobed throughout.
    col = 4'b1011;
    clear_stats(); rec_en = 1'b1;
    key_code = 4'b0110; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    wait_idle(60, "single_idle");
    rec_en = 1'b0;
    check("single_active_len", 32'(act_n),     32'(HOLD));
    check("single_row_len",    32'(row_n),     32'(HOLD));
    check("single_row_lag",    32'(first_row), 32'(first_act + 1));
    check("single_done_n",     32'(done_n),    32'd1);
    check("single_done_pos",   (done_t.size() > 0) ? 32'(done_t[0]) : 32'hFFFF_FFFF,
          32'(first_act + HOLD));
    exp_rows.delete(); exp_rows.push_back(4'b1101);
    check_rows("single_row_val");
    check("single_end_row", 32'(row), 32'hF);

    // Scan response while key 1100 is pressed.
    col = COL_IDLE;
    key_code = 4'b1100; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    tick();
    check("scan_active", 32'(active), 32'd1);
    check("scan_row_entry", 32'(row), 32'hF);
    for (int j = 0; j < 8; j++) begin
      col = scan_tbl[j].col;
      tick();
      check($sformatf("scan_row[%0d]", j), 32'(row), 32'(scan_tbl[j].exp_row));
    end
    col = COL_IDLE;
    wait_idle(40, "scan_idle");

    // Queue full.
    col = 4'b0000;
    clear_stats(); rec_en = 1'b1;
    key_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      key_code = push_tbl[i].code;
      tick();
      check($sformatf("full_ready[%0d]", i), 32'(key_ready), 32'(push_tbl[i].exp_ready));
    end
    key_valid = 1'b0;
    wait_idle(120, "full_idle");
    rec_en = 1'b0;
    check("full_done_n", 32'(done_n), 32'd5);
    check("full_active_len", 32'(act_n), 32'(5 * HOLD));
    check_spacing("full_done_spacing");
    exp_rows.delete();
    exp_rows.push_back(4'b1110); exp_rows.push_back(4'b1101); exp_rows.push_back(4'b1011);
    exp_rows.push_back(4'b0111); exp_rows.push_back(4'b1110);
    check_rows("full_order");

    // Reset in the third PRESS cycle with two keys still queued.
    col = 4'b0000;
    key_valid = 1'b1; key_code = 4'b0110;
    tick();
    key_code = 4'b1011;
    tick();
    key_code = 4'b1100;
    tick();
    key_valid = 1'b0;
    tick();
    check("mid_active", 32'(active), 32'd1);
    check("mid_row",    32'(row),    32'hD);
    check("mid_busy",   32'(busy),   32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_row",    32'(row),       32'hF);
    check("mid_rst_active", 32'(active),    32'd0);
    check("mid_rst_busy",   32'(busy),      32'd0);
    check("mid_rst_done",   32'(done),      32'd0);
    check("mid_rst_ready",  32'(key_ready), 32'd1);
    rst = 1'b0;
    clear_stats(); rec_en = 1'b1;
    repeat (40) tick();
    rec_en = 1'b0;
    check("mid_after_active", 32'(act_n),  32'd0);
    check("mid_after_done",   32'(done_n), 32'd0);
    check("mid_after_row",    32'(row_n),  32'd0);

    // Push on the same edge the sequencer pops, with two keys queued.
    col = 4'b0000;
    key_code = 4'b0001; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (done === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      check("simul_done_seen", 32'(seen), 32'd1);
    end
    key_code = 4'b0110; key_valid = 1'b1;
    tick();
    key_code = 4'b1011;
    tick();
    key_valid = 1'b0;
    tick(); tick();
    check("simul_idle_active", 32'(active), 32'd0);
    check("simul_idle_busy",   32'(busy),   32'd1);
    clear_stats(); rec_en = 1'b1;
    key_code = 4'b1100; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    check("simul_pop_active", 32'(active),    32'd1);
    check("simul_pop_ready",  32'(key_ready), 32'd1);
    wait_idle(80, "simul_idle_end");
    rec_en = 1'b0;
    check("simul_done_n", 32'(done_n), 32'd3);
    check_spacing("simul_done_spacing");
    exp_rows.delete();
    exp_rows.push_back(4'b1101); exp_rows.push_back(4'b1011); exp_rows.push_back(4'b0111);
    check_rows("simul_order");

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_n, total_n);
    $fatal(1);
  end

endmodule
